uart_rx_ovs: RTL and testbench

Oversampling UART receiver with a built-in receive FIFO. It is the parametrised successor of the basic 8N1 receiver: data width, parity, stop-bit count, oversampling ratio and FIFO depth are all configurable. It adds majority-vote sampling, false-start rejection, per-word parity and framing error flags, and overrun detection. It sits between the board RX pin and any AXI-Stream consumer in the fabric, such as the LED or command decoders.

---
 rtl/uart_rx_ovs.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with majority-vote sampling, parity and framing
// checks, and a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_ovs #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int N_BITS     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_data,
    output logic [N_BITS-1:0]             uart_rx_tdata,
    output logic [1:0]                    uart_rx_tuser,
    output logic                          uart_rx_tvalid,
    input  logic                          uart_rx_tready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TICK_DIV = (CLK_FREQ + BAUD_RATE * OVS / 2) / (BAUD_RATE * OVS);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TCK_W    = $clog2(OVS);
    localparam int BIT_W    = $clog2(N_BITS);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int WORD_W   = N_BITS + 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [TCK_W-1:0] TCK_S0   = TCK_W'(OVS / 2 - 1);
    localparam logic [TCK_W-1:0] TCK_S1   = TCK_W'(OVS / 2);
    localparam logic [TCK_W-1:0] TCK_DEC  = TCK_W'(OVS / 2 + 1);
    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Odd mode expects data^parity == 1, even mode expects 0.
    function automatic logic parity_mismatch_f(input logic [N_BITS-1:0] data, input logic pbit);
        logic want_s;
        want_s = (PARITY == 1) ? 1'b1 : 1'b0;
        return ((^data) ^ pbit) != want_s;
    endfunction

    logic                r_sync1, r_sync2, r_rxs_d;
    state_t              r_state, w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [TCK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_stop_cnt;
    logic                r_smp0, r_smp1;
    logic [N_BITS-1:0]   r_shift;
    logic                r_perr, r_ferr;
    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overrun;

    logic                w_rxs, w_start_edge, w_tick, w_decide, w_bit_end, w_maj;
    logic                w_push, w_push_ok, w_pop, w_full, w_drop;
    logic [WORD_W-1:0]   w_word, w_head;

    assign w_rxs        = r_sync2;
    assign w_start_edge = r_rxs_d & ~w_rxs;
    assign w_tick       = (r_div == DIV_LAST);
    assign w_decide     = w_tick && (r_tick_cnt == TCK_DEC);
    assign w_bit_end    = w_tick && (r_tick_cnt == TCK_LAST);
    assign w_maj        = (r_smp0 & r_smp1) | (r_smp0 & w_rxs) | (r_smp1 & w_rxs);
    // The stop-bit decision itself can still flag a framing error.
    assign w_word       = {r_perr, r_ferr | ~w_maj, r_shift};

    // Two-flop synchroniser plus delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and push strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == BIT_LAST)) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_STOP: begin
                if (w_decide && (r_stop_cnt == STOP_LAST)) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Tick divider, per-bit tick/bit counters, samples and received word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= {DIV_W{1'b0}};
            r_tick_cnt <= {TCK_W{1'b0}};
            r_bit_cnt  <= {BIT_W{1'b0}};
            r_stop_cnt <= 1'b0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_shift    <= {N_BITS{1'b0}};
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (((r_state == S_IDLE) && w_start_edge) || w_tick) begin
                r_div <= {DIV_W{1'b0}};
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_tick_cnt <= {TCK_W{1'b0}};
            end else if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == TCK_LAST) ? {TCK_W{1'b0}} : r_tick_cnt + 1'b1;
            end

            if (w_tick && (r_tick_cnt == TCK_S0)) begin
                r_smp0 <= w_rxs;
            end
            if (w_tick && (r_tick_cnt == TCK_S1)) begin
                r_smp1 <= w_rxs;
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= {BIT_W{1'b0}};
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state != S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (w_bit_end) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_shift <= {N_BITS{1'b0}};
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
            end else begin
                if ((r_state == S_DATA) && w_decide) begin
                    r_shift <= {w_maj, r_shift[N_BITS-1:1]};
                end
                if ((r_state == S_PARITY) && w_decide) begin
                    r_perr <= parity_mismatch_f(r_shift, w_maj);
                end
                if ((r_state == S_STOP) && w_decide && !w_maj) begin
                    r_ferr <= 1'b1;
                end
            end
        end
    end

    assign w_pop     = uart_rx_tvalid & uart_rx_tready;
    assign w_full    = (r_count == FULL_CNT);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    // FIFO storage, pointers, occupancy and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {WORD_W{1'b0}};
            end
            r_wptr    <= {PTR_W{1'b0}};
            r_rptr    <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign uart_rx_tdata  = w_head[N_BITS-1:0];
    assign uart_rx_tuser  = w_head[WORD_W-1:N_BITS];
    assign uart_rx_tvalid = (r_count != {CNT_W{1'b0}});
    assign overrun        = r_overrun;
    assign fifo_count     = r_count;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: three instances (8N1/depth 4, 8E1, 8N2)
// driven with hand-built frames at 18.432 MHz / 115200 baud, 160 clk per bit.
module tb_uart_rx_ovs;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_v;
    logic       tready_a, tready_b, tready_c;
    logic [7:0] tdata_a, tdata_b, tdata_c;
    logic [1:0] tuser_a, tuser_b, tuser_c;
    logic       tvalid_a, tvalid_b, tvalid_c;
    logic       overrun_a, overrun_b, overrun_c;
    logic [2:0] count_a;
    logic [4:0] count_b, count_c;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_c[$];
    logic [7:0]  skew_v [3];

    always #5 clk = ~clk;

    uart_rx_ovs #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .N_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVS(16), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_v[0]), .uart_rx_tdata(tdata_a),
        .uart_rx_tuser(tuser_a), .uart_rx_tvalid(tvalid_a), .uart_rx_tready(tready_a),
        .overrun(overrun_a), .fifo_count(count_a));

    uart_rx_ovs #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .N_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVS(16), .FIFO_DEPTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_v[1]), .uart_rx_tdata(tdata_b),
        .uart_rx_tuser(tuser_b), .uart_rx_tvalid(tvalid_b), .uart_rx_tready(tready_b),
        .overrun(overrun_b), .fifo_count(count_b));

    uart_rx_ovs #(.CLK_FREQ(18_432_000), .BAUD_RATE(115200), .N_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .OVS(16), .FIFO_DEPTH(16)) u_dut_c (
        .clk(clk), .rst(rst), .rx_data(rx_v[2]), .uart_rx_tdata(tdata_c),
        .uart_rx_tuser(tuser_c), .uart_rx_tvalid(tvalid_c), .uart_rx_tready(tready_c),
        .overrun(overrun_c), .fifo_count(count_c));

    // Record every accepted word as {tuser, tdata}.
    always @(negedge clk) begin
        if (!rst && tvalid_a && tready_a) q_a.push_back({22'd0, tuser_a, tdata_a});
        if (!rst && tvalid_b && tready_b) q_b.push_back({22'd0, tuser_b, tdata_b});
        if (!rst && tvalid_c && tready_c) q_c.push_back({22'd0, tuser_c, tdata_c});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_q(input int idx);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (idx)
            0: if (q_a.size() > 0) v = q_a.pop_front();
            1: if (q_b.size() > 0) v = q_b.pop_front();
            default: if (q_c.size() > 0) v = q_c.pop_front();
        endcase
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bits go out LSB first, each held for 'period' clocks.
    task automatic send_raw(input int idx, input logic [15:0] bits, input int len, input int period);
        for (int i = 0; i < len; i++) begin
            rx_v[idx] = bits[i];
            cycles(period);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        skew_v   = '{8'h00, 8'hFF, 8'h5A};
        rst      = 1'b1;
        rx_v     = 3'b111;
        tready_a = 1'b0;
        tready_b = 1'b0;
        tready_c = 1'b0;
        @(posedge clk);
        #1;
        cycles(5);
        check_eq("rst_tvalid_a", {31'd0, tvalid_a}, 32'd0);
        check_eq("rst_count_a", {29'd0, count_a}, 32'd0);
        check_eq("rst_overrun_a", {31'd0, overrun_a}, 32'd0);
        check_eq("rst_tdata_a", {24'd0, tdata_a}, 32'd0);
        check_eq("rst_tuser_a", {30'd0, tuser_a}, 32'd0);
        check_eq("rst_tvalid_bc", {30'd0, tvalid_b, tvalid_c}, 32'd0);
        rst = 1'b0;
        cycles(5);

        // 8N1 single word with the consumer always ready
        tready_a = 1'b1;
        send_raw(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 160);
        cycles(20);
        check_eq("a5_word", pop_q(0), 32'h0A5);
        check_eq("a5_no_extra", q_a.size(), 32'd0);
        check_eq("a5_count", {29'd0, count_a}, 32'd0);

        // 10-bit break -> data 0 with frame_err only
        rx_v[0] = 1'b0;
        cycles(1600);
        rx_v[0] = 1'b1;
        cycles(300);
        check_eq("break_word", pop_q(0), 32'h100);
        check_eq("break_no_extra", q_a.size(), 32'd0);

        // 3-clk glitch is a false start; a normal word must follow cleanly
        rx_v[0] = 1'b0;
        cycles(3);
        rx_v[0] = 1'b1;
        cycles(400);
        check_eq("glitch_nothing", q_a.size(), 32'd0);
        send_raw(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 160);
        cycles(20);
        check_eq("after_glitch", pop_q(0), 32'h03C);

        // Fill the depth-4 FIFO
        tready_a = 1'b0;
        for (int i = 1; i <= 4; i++) send_raw(0, {6'd0, 1'b1, 8'(i), 1'b0}, 10, 160);
        cycles(20);
        check_eq("fill_count", {29'd0, count_a}, 32'd4);
        check_eq("fill_overrun", {31'd0, overrun_a}, 32'd0);
        check_eq("fill_head", {22'd0, tuser_a, tdata_a}, 32'h001);

        // Push lands at clock 1543 after the start bit is driven; pop in that cycle
        fork
            send_raw(0, {6'd0, 1'b1, 8'h06, 1'b0}, 10, 160);
            begin
                cycles(1542);
                tready_a = 1'b1;
                cycles(1);
                tready_a = 1'b0;
            end
        join
        cycles(20);
        check_eq("fullpop_popped", pop_q(0), 32'h001);
        check_eq("fullpop_count", {29'd0, count_a}, 32'd4);
        check_eq("fullpop_overrun", {31'd0, overrun_a}, 32'd0);

        // Full with no pop: word dropped
        send_raw(0, {6'd0, 1'b1, 8'h07, 1'b0}, 10, 160);
        cycles(20);
        check_eq("ovr_count", {29'd0, count_a}, 32'd4);
        check_eq("ovr_flag", {31'd0, overrun_a}, 32'd1);
        tready_a = 1'b1;
        cycles(10);
        check_eq("drain_0", pop_q(0), 32'h002);
        check_eq("drain_1", pop_q(0), 32'h003);
        check_eq("drain_2", pop_q(0), 32'h004);
        check_eq("drain_3", pop_q(0), 32'h006);
        check_eq("drain_empty", q_a.size(), 32'd0);
        check_eq("drain_count", {29'd0, count_a}, 32'd0);
        check_eq("drain_overrun_sticky", {31'd0, overrun_a}, 32'd1);

        // 8E1: 0x37 has five ones, so even parity bit is 1
        tready_b = 1'b1;
        send_raw(1, {5'd0, 1'b1, 1'b1, 8'h37, 1'b0}, 11, 160);
        send_raw(1, {5'd0, 1'b1, 1'b0, 8'h37, 1'b0}, 11, 160);
        send_raw(1, {5'd0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 160);
        cycles(20);
        check_eq("par_good_37", pop_q(1), 32'h037);
        check_eq("par_bad_37", pop_q(1), 32'h237);
        check_eq("par_bad_00", pop_q(1), 32'h200);

        // 8N2 back-to-back at 155 clk per bit
        tready_c = 1'b1;
        for (int i = 0; i < 3; i++) send_raw(2, {5'd0, 2'b11, skew_v[i], 1'b0}, 11, 155);
        cycles(20);
        check_eq("skew_00", pop_q(2), 32'h000);
        check_eq("skew_ff", pop_q(2), 32'h0FF);
        check_eq("skew_5a", pop_q(2), 32'h05A);

        // Second stop bit low -> frame_err
        send_raw(2, {5'd0, 1'b0, 1'b1, 8'h81, 1'b0}, 11, 160);
        rx_v[2] = 1'b1;
        cycles(20);
        check_eq("stop2_ferr", pop_q(2), 32'h181);

        // Second stop decision is tick 169 -> push at clock 1703
        tready_c = 1'b0;
        fork
            send_raw(2, {5'd0, 2'b11, 8'h33, 1'b0}, 11, 160);
            begin
                cycles(1702);
                check_eq("lat_before", {31'd0, tvalid_c}, 32'd0);
                cycles(1);
                check_eq("lat_after", {31'd0, tvalid_c}, 32'd1);
                check_eq("lat_data", {24'd0, tdata_c}, 32'h33);
            end
        join
        cycles(20);
        check_eq("lat_count", {27'd0, count_c}, 32'd1);

        // Reset during a high data bit of 0xF0: frame aborted, FIFO emptied
        fork
            send_raw(2, {5'd0, 2'b11, 8'hF0, 1'b0}, 11, 160);
            begin
                cycles(820);
                rst = 1'b1;
                cycles(4);
                rst = 1'b0;
            end
        join
        cycles(50);
        check_eq("rstmid_tvalid", {31'd0, tvalid_c}, 32'd0);
        check_eq("rstmid_count", {27'd0, count_c}, 32'd0);
        check_eq("rstmid_overrun_a", {31'd0, overrun_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
